// File: rtl/pmp_check_arbiter.sv
// Shares one combinational PMP checker between the fetch port and the LSU.
// Arbitrates, latches the winning access, captures the fault and returns it.
module pmp_check_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter bit          FAIR   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        priv_mode,
  input  logic              csr_pmp_wr,
  input  logic              if_flush,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_resp_valid,
  input  logic              if_resp_ready,
  output logic              if_resp_fault,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic              lsu_req_we,
  input  logic              lsu_req_re,
  output logic              lsu_resp_valid,
  input  logic              lsu_resp_ready,
  output logic              lsu_resp_fault,
  output logic [ADDR_W-1:0] pmp_addr,
  output logic              pmp_we,
  output logic              pmp_re,
  output logic              pmp_xe,
  output logic [1:0]        pmp_priv,
  input  logic              pmp_access_fault
);

  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, RESP = 2'd2} state_t;

  state_t state, state_n;
  logic   own, last, fault_q, we_q, re_q, xe_q;
  logic   if_cand, grant_if, grant_lsu, accept, capture;
  logic   chk_n, resp_n, fault_n;

  // A flushed fetch never competes; contention resolves by FAIR
  always_comb begin
    if_cand   = if_req_valid & ~if_flush;
    grant_lsu = lsu_req_valid & (~if_cand | (FAIR ? ~last : 1'b1));
    grant_if  = if_cand & ~grant_lsu;
  end

  assign if_req_ready  = rst_n & (state == IDLE) & grant_if;
  assign lsu_req_ready = rst_n & (state == IDLE) & grant_lsu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (if_req_ready | lsu_req_ready) begin
          accept  = 1'b1;
          state_n = CHECK;
        end
      end
      CHECK: begin
        // A CSR write makes this cycle's checker result stale: check again
        if (!own && if_flush) begin
          state_n = IDLE;
        end else if (!csr_pmp_wr) begin
          capture = 1'b1;
          state_n = RESP;
        end
      end
      RESP: begin
        if (own ? lsu_resp_ready : (if_resp_ready | if_flush)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    chk_n   = (state_n == CHECK);
    resp_n  = (state_n == RESP);
    fault_n = capture ? pmp_access_fault : fault_q;
  end

  // Access latch, ownership and captured fault
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pmp_addr <= '0;
      pmp_priv <= 2'b00;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      xe_q     <= 1'b0;
      own      <= 1'b0;
      last     <= 1'b1;
      fault_q  <= 1'b0;
    end else begin
      if (accept) begin
        pmp_addr <= grant_lsu ? lsu_req_addr : if_req_addr;
        pmp_priv <= priv_mode;
        we_q     <= grant_lsu & lsu_req_we;
        re_q     <= grant_lsu & lsu_req_re;
        xe_q     <= grant_if;
        own      <= grant_lsu;
        last     <= grant_lsu;
      end
      if (capture) fault_q <= pmp_access_fault;
    end
  end

  // Registered outputs, computed from next state so each owner's view is glitch-free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pmp_we         <= 1'b0;
      pmp_re         <= 1'b0;
      pmp_xe         <= 1'b0;
      if_resp_valid  <= 1'b0;
      if_resp_fault  <= 1'b0;
      lsu_resp_valid <= 1'b0;
      lsu_resp_fault <= 1'b0;
    end else begin
      pmp_we         <= chk_n & (accept ? (grant_lsu & lsu_req_we) : we_q);
      pmp_re         <= chk_n & (accept ? (grant_lsu & lsu_req_re) : re_q);
      pmp_xe         <= chk_n & (accept ? grant_if : xe_q);
      if_resp_valid  <= resp_n & ~own;
      if_resp_fault  <= resp_n & ~own & fault_n;
      lsu_resp_valid <= resp_n & own;
      lsu_resp_fault <= resp_n & own & fault_n;
    end
  end

endmodule

// File: tb/tb_pmp_check_arbiter.sv
// Directed bench for pmp_check_arbiter: latency, faults, arbitration,
// CSR re-check, fetch flush and mid-transaction reset.
module tb_pmp_check_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  priv_mode;
  logic        csr_pmp_wr, if_flush;
  logic        if_req_valid, if_resp_ready;
  logic [31:0] if_req_addr;
  logic        lsu_req_valid, lsu_req_we, lsu_req_re, lsu_resp_ready;
  logic [31:0] lsu_req_addr;
  logic        pmp_access_fault;

  logic        if_req_ready, if_resp_valid, if_resp_fault;
  logic        lsu_req_ready, lsu_resp_valid, lsu_resp_fault;
  logic [31:0] pmp_addr;
  logic        pmp_we, pmp_re, pmp_xe;
  logic [1:0]  pmp_priv;

  logic        d0_if_req_ready, d0_if_resp_valid, d0_if_resp_fault;
  logic        d0_lsu_req_ready, d0_lsu_resp_valid, d0_lsu_resp_fault;
  logic [31:0] d0_pmp_addr;
  logic        d0_pmp_we, d0_pmp_re, d0_pmp_xe;
  logic [1:0]  d0_pmp_priv;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pmp_check_arbiter #(.ADDR_W(32), .FAIR(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .priv_mode(priv_mode), .csr_pmp_wr(csr_pmp_wr),
    .if_flush(if_flush), .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
    .if_req_addr(if_req_addr), .if_resp_valid(if_resp_valid),
    .if_resp_ready(if_resp_ready), .if_resp_fault(if_resp_fault),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_req_addr(lsu_req_addr), .lsu_req_we(lsu_req_we), .lsu_req_re(lsu_req_re),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
    .lsu_resp_fault(lsu_resp_fault), .pmp_addr(pmp_addr), .pmp_we(pmp_we),
    .pmp_re(pmp_re), .pmp_xe(pmp_xe), .pmp_priv(pmp_priv),
    .pmp_access_fault(pmp_access_fault)
  );

  pmp_check_arbiter #(.ADDR_W(32), .FAIR(1'b0)) u_dut_fixed (
    .clk(clk), .rst_n(rst_n), .priv_mode(priv_mode), .csr_pmp_wr(csr_pmp_wr),
    .if_flush(if_flush), .if_req_valid(if_req_valid), .if_req_ready(d0_if_req_ready),
    .if_req_addr(if_req_addr), .if_resp_valid(d0_if_resp_valid),
    .if_resp_ready(if_resp_ready), .if_resp_fault(d0_if_resp_fault),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(d0_lsu_req_ready),
    .lsu_req_addr(lsu_req_addr), .lsu_req_we(lsu_req_we), .lsu_req_re(lsu_req_re),
    .lsu_resp_valid(d0_lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
    .lsu_resp_fault(d0_lsu_resp_fault), .pmp_addr(d0_pmp_addr), .pmp_we(d0_pmp_we),
    .pmp_re(d0_pmp_re), .pmp_xe(d0_pmp_xe), .pmp_priv(d0_pmp_priv),
    .pmp_access_fault(pmp_access_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " if_req_ready"},   32'(if_req_ready),   32'd0);
    chk({tag, " lsu_req_ready"},  32'(lsu_req_ready),  32'd0);
    chk({tag, " if_resp_valid"},  32'(if_resp_valid),  32'd0);
    chk({tag, " lsu_resp_valid"}, 32'(lsu_resp_valid), 32'd0);
    chk({tag, " resp_faults"},    32'({if_resp_fault, lsu_resp_fault}), 32'd0);
    chk({tag, " pmp_addr"},       pmp_addr,            32'd0);
    chk({tag, " pmp_en"},         32'({pmp_we, pmp_re, pmp_xe}), 32'd0);
    chk({tag, " pmp_priv"},       32'(pmp_priv),       32'd0);
  endtask

  initial begin
    rst_n = 1'b0; priv_mode = 2'b00; csr_pmp_wr = 1'b0; if_flush = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 32'h0; if_resp_ready = 1'b0;
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h0; lsu_req_we = 1'b0; lsu_req_re = 1'b0;
    lsu_resp_ready = 1'b0; pmp_access_fault = 1'b0;
    #2;
    chk_all_zero("reset");
    if_req_valid = 1'b0; lsu_req_valid = 1'b0;
    #10 rst_n = 1'b1;
    tick();

    // IF alone, no fault
    if_req_valid = 1'b1; if_req_addr = 32'h0000_1000; priv_mode = 2'b00;
    #1;
    chk("if_alone ready N", 32'(if_req_ready), 32'd1);
    chk("if_alone lsu_ready N", 32'(lsu_req_ready), 32'd0);
    chk("if_alone xe N", 32'(pmp_xe), 32'd0);
    tick();
    if_req_valid = 1'b0;
    #1;
    chk("if_alone xe N+1", 32'(pmp_xe), 32'd1);
    chk("if_alone addr N+1", pmp_addr, 32'h0000_1000);
    chk("if_alone resp N+1", 32'(if_resp_valid), 32'd0);
    tick();
    chk("if_alone resp N+2", 32'(if_resp_valid), 32'd1);
    chk("if_alone fault N+2", 32'(if_resp_fault), 32'd0);
    chk("if_alone xe N+2", 32'(pmp_xe), 32'd0);
    if_resp_ready = 1'b1;
    tick();
    chk("if_alone resp done", 32'(if_resp_valid), 32'd0);
    if_resp_ready = 1'b0;

    // LSU store that faults, held response
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_0000; lsu_req_we = 1'b1;
    lsu_req_re = 1'b0; priv_mode = 2'b01;
    #1;
    chk("lsu_st ready N", 32'(lsu_req_ready), 32'd1);
    tick();
    lsu_req_valid = 1'b0; lsu_req_we = 1'b0; pmp_access_fault = 1'b1;
    #1;
    chk("lsu_st en N+1", 32'({pmp_we, pmp_re, pmp_xe}), 32'b100);
    chk("lsu_st priv N+1", 32'(pmp_priv), 32'd1);
    chk("lsu_st addr N+1", pmp_addr, 32'h8000_0000);
    tick();
    pmp_access_fault = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("lsu_st resp held", 32'({lsu_resp_valid, lsu_resp_fault, if_resp_valid}), 32'b110);
      tick();
    end
    lsu_resp_ready = 1'b1;
    tick();
    chk("lsu_st released", 32'({lsu_resp_valid, lsu_resp_fault, pmp_we}), 32'd0);
    lsu_resp_ready = 1'b0;

    // Continuous contention: FAIR alternates starting with IF, fixed always LSU
    if_req_valid = 1'b1; lsu_req_valid = 1'b1; lsu_req_re = 1'b1;
    if_req_addr = 32'h0000_4000; lsu_req_addr = 32'h0000_5000;
    if_resp_ready = 1'b1; lsu_resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      automatic logic exp_if = (i % 2 == 0);
      #1;
      chk("fair grant if", 32'(if_req_ready), 32'(exp_if));
      chk("fair grant lsu", 32'(lsu_req_ready), 32'(!exp_if));
      chk("fixed grant", 32'({d0_lsu_req_ready, d0_if_req_ready}), 32'b10);
      tick();
      tick();
      chk("fair resp owner", 32'({if_resp_valid, lsu_resp_valid}), 32'({exp_if, !exp_if}));
      tick();
    end
    if_req_valid = 1'b0; lsu_req_valid = 1'b0; lsu_req_re = 1'b0;
    if_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
    tick();

    // CSR write during CHECK forces a re-check with the newer checker result
    if_req_valid = 1'b1; if_req_addr = 32'h0000_2000;
    #1;
    chk("csr ready N", 32'(if_req_ready), 32'd1);
    tick();
    if_req_valid = 1'b0; csr_pmp_wr = 1'b1;
    tick();
    csr_pmp_wr = 1'b0; pmp_access_fault = 1'b1;
    #1;
    chk("csr resp N+2", 32'(if_resp_valid), 32'd0);
    chk("csr xe N+2", 32'(pmp_xe), 32'd1);
    tick();
    chk("csr resp N+3", 32'({if_resp_valid, if_resp_fault}), 32'b11);
    pmp_access_fault = 1'b0; csr_pmp_wr = 1'b1;
    tick();
    chk("csr in resp ignored", 32'({if_resp_valid, if_resp_fault}), 32'b11);
    csr_pmp_wr = 1'b0; if_resp_ready = 1'b1;
    tick();
    chk("csr done", 32'(if_resp_valid), 32'd0);
    if_resp_ready = 1'b0;

    // Flush in RESP drops the fetch; a waiting LSU request goes next
    if_req_valid = 1'b1; if_req_addr = 32'h0000_6000;
    #1;
    chk("flush ready N", 32'(if_req_ready), 32'd1);
    tick();
    if_req_valid = 1'b0; lsu_req_valid = 1'b1; lsu_req_addr = 32'h0000_7000; lsu_req_re = 1'b1;
    #1;
    chk("flush lsu wait", 32'(lsu_req_ready), 32'd0);
    tick();
    chk("flush resp before", 32'(if_resp_valid), 32'd1);
    if_flush = 1'b1;
    tick();
    if_flush = 1'b0;
    #1;
    chk("flush resp dropped", 32'(if_resp_valid), 32'd0);
    chk("flush lsu granted", 32'(lsu_req_ready), 32'd1);
    tick();
    lsu_req_valid = 1'b0; lsu_req_re = 1'b0; if_flush = 1'b1;
    tick();
    if_flush = 1'b0;
    chk("flush lsu unaffected", 32'({lsu_resp_valid, lsu_resp_fault}), 32'b10);
    lsu_resp_ready = 1'b1;
    tick();
    lsu_resp_ready = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 32'h0000_3000; if_flush = 1'b1;
    #1;
    chk("flush masks idle req", 32'(if_req_ready), 32'd0);
    if_flush = 1'b0;
    #1;
    chk("unmasked idle req", 32'(if_req_ready), 32'd1);

    // Reset during CHECK discards the access
    tick();
    if_req_valid = 1'b0;
    #1;
    chk("rst pre xe", 32'(pmp_xe), 32'd1);
    chk("rst pre addr", pmp_addr, 32'h0000_3000);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst mid");
    #1 rst_n = 1'b1;
    if_resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst no stale resp", 32'({if_resp_valid, lsu_resp_valid, pmp_xe}), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pmp_check_arbiter.md
# pmp_check_arbiter

Shares a single combinational `pmp` checker between the instruction-fetch port and the load/store unit. The block arbitrates requests, latches the winning access into a check register that drives the checker, captures the fault result, and returns it over a valid/ready response handshake. It sits between the IF/LSU stages and the `pmp` instance. It also re-checks any access in flight when PMP CSRs change and drops fetch transactions on pipeline flush.

## Interface
- `ADDR_W`, 32, address width passed to the checker.
- `FAIR`, 1, 1 = round-robin on contention; 0 = fixed LSU priority.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `priv_mode`  in  2  current privilege (00 U, 01 S, 11 M); sampled at grant.
- `csr_pmp_wr`  in  1  one-cycle pulse on any pmpcfg/pmpaddr write.
- `if_flush`  in  1  kill any fetch transaction in flight.
- `if_req_valid`  in  1  fetch check request.
- `if_req_ready`  out  1  fetch request accepted this cycle.
- `if_req_addr`  in  ADDR_W  fetch address.
- `if_resp_valid`  out  1  fetch result valid.
- `if_resp_ready`  in  1  fetch result consumed.
- `if_resp_fault`  out  1  fetch access fault.
- `lsu_req_valid`  in  1  data check request.
- `lsu_req_ready`  out  1  data request accepted.
- `lsu_req_addr`  in  ADDR_W  data address.
- `lsu_req_we`, `lsu_req_re`  in  1 each  store / load.
- `lsu_resp_valid`  out  1  data result valid.
- `lsu_resp_ready`  in  1  data result consumed.
- `lsu_resp_fault`  out  1  data access fault.
- `pmp_addr`  out  ADDR_W  to checker.
- `pmp_we`, `pmp_re`, `pmp_xe`  out  1 each  to checker.
- `pmp_priv`  out  2  to checker.
- `pmp_access_fault`  in  1  from checker (combinational).

## Operation
- FSM states: IDLE, CHECK, RESP. Owner register `own` (0 = IF, 1 = LSU). Last-grant register `last`.
- IDLE:
  - Grant is combinational. With only one valid requester, that requester wins.
  - With both valid: FAIR=1 grants the requester other than `last`; FAIR=0 grants LSU.
  - `xx_req_ready` = (state==IDLE) & grant_xx, so at most one ready is high.
  - On handshake, latch addr, priv_mode, and enables: IF gets xe=1, we=re=0; LSU gets xe=0 with its we/re. Set `own` and `last`, then go to CHECK.
- CHECK:
  - `pmp_*` is driven from the latched registers.
  - At the end of the cycle, capture `pmp_access_fault` into `fault_q` and go to RESP.
  - If `csr_pmp_wr` is high this cycle, do not capture; stay in CHECK one more cycle and repeat on every consecutive pulse.
- RESP:
  - The owner's `resp_valid` is 1 and its `resp_fault` is `fault_q`. The non-owner's `resp_valid` and `resp_fault` are 0.
  - Hold until owner `resp_ready`=1, then go to IDLE.
  - `fault_q` is final once in RESP; a `csr_pmp_wr` here has no effect.
- Outside CHECK/RESP, `pmp_we/re/xe` = 0 and `pmp_addr`/`pmp_priv` hold their last latched values. The LSU latch passes we=re=0 through unchanged, and the checker then reports no fault.
- `if_flush`:
  - If own=IF in CHECK or RESP, go to IDLE next cycle with no response; `if_resp_valid` drops to 0 the following cycle.
  - In IDLE, flush masks the IF request (no IF grant that cycle).
  - Flush has no effect on LSU transactions.
- Simultaneous `if_flush` and IF resp handshake in RESP: treated as a completed handshake, next state IDLE.

## Timing
- Reset (async assert, sync deassert by system):
  - state=IDLE, own=0, last=1 so that IF wins first contention under FAIR=1.
  - fault_q=0 and all latched registers 0.
  - All outputs 0: both req_ready, both resp_valid, both resp_fault, pmp_addr, pmp_we/re/xe, pmp_priv.
- Reset mid-transaction discards it; no response is ever issued for it.
- Latency: request handshake in cycle N, CHECK in N+1, resp_valid in N+2 (one extra cycle per `csr_pmp_wr` pulse seen in CHECK).
- Minimum occupancy is 3 cycles per access (accept, check, respond with immediate ready), with a new request accepted in the cycle after the response handshake.
- `resp_valid` and `resp_fault` are registered, stable until handshake, and never glitch between owners.

## Test plan
- IF alone: addr 0x0000_1000, priv 00, checker fault=0. Expect `if_req_ready`=1 in cycle N, `if_resp_valid`=1 in N+2 with fault 0, and `pmp_xe`=1 only in N+1.
- LSU store faulting: addr 0x8000_0000, we=1, priv 01, checker fault=1 in CHECK. Expect `lsu_resp_fault`=1 held 3 cycles while `lsu_resp_ready`=0, released on ready, then IDLE.
- Contention, FAIR=1, both requesters valid continuously: grants after reset are IF, LSU, IF, LSU. With FAIR=0 the grant is always LSU.
- `csr_pmp_wr` pulse during CHECK, with checker fault changing 0 to 1 in the next cycle: expect resp_valid in N+3 and fault=1.
- `if_flush` in RESP for IF: `if_resp_valid` goes to 0 next cycle and a pending LSU request is granted the cycle after.
- `rst_n` low during CHECK: all outputs 0 immediately; after release, no stale response appears.
